// File: rtl/subservient_dbg_loader_pkg.sv
// -----------------------------------------------------------------------------
// subservient_dbg_pkg
// Shared definitions for the subservient debug-port firmware loader:
//   - state_e      : loader FSM states (VERIFY is only reachable when readback
//                    checking is compiled in)
//   - SEL_ALL      : full-word Wishbone byte select
//   - DRAIN_CW     : width of the post-load drain counter
//   - insert_byte  : places a byte into one lane of a 32-bit word
//   - lane_keep_mask : keeps lanes 0..lane, zeroes everything above
// -----------------------------------------------------------------------------
package subservient_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    localparam logic [3:0] SEL_ALL  = 4'b1111;
    localparam int         DRAIN_CW = 8;

    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_keep_mask(input logic [1:0] lane);
        logic [31:0] mask;
        case (lane)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            2'd2:    mask = 32'h00FF_FFFF;
            2'd3:    mask = 32'hFFFF_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/subservient_dbg_loader_if.sv
// -----------------------------------------------------------------------------
// subservient_dbg_loader_if
// Bundles the loader's byte-stream input and its Wishbone debug master port.
//   master : loader side (consumes the stream, drives Wishbone requests)
//   slave  : environment side (produces the stream, answers Wishbone requests)
// Stream : i_data[7:0], i_valid, i_last -> ; o_ready <-
// Wishbone: o_wb_dbg_adr/dat[31:0], o_wb_dbg_sel[3:0], o_wb_dbg_we,
//           o_wb_dbg_stb -> ; i_wb_dbg_rdt[31:0], i_wb_dbg_ack <-
// -----------------------------------------------------------------------------
interface subservient_dbg_loader_if;

    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_last;
    logic        o_ready;

    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic [31:0] i_wb_dbg_rdt;
    logic        i_wb_dbg_ack;

    modport master (
        input  i_data, i_valid, i_last, i_wb_dbg_rdt, i_wb_dbg_ack,
        output o_ready, o_wb_dbg_adr, o_wb_dbg_dat, o_wb_dbg_sel,
               o_wb_dbg_we, o_wb_dbg_stb
    );

    modport slave (
        output i_data, i_valid, i_last, i_wb_dbg_rdt, i_wb_dbg_ack,
        input  o_ready, o_wb_dbg_adr, o_wb_dbg_dat, o_wb_dbg_sel,
               o_wb_dbg_we, o_wb_dbg_stb
    );

endinterface

// File: rtl/subservient_dbg_loader_packer.sv
// -----------------------------------------------------------------------------
// subservient_dbg_packer
// Packs accepted stream bytes little-endian into a 32-bit word and keeps the
// image byte count, including the overflow decision at count == memsize.
// Ports:
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_clear           : start of a new load; empties word and count
//   i_accept          : a stream byte is handshaken this cycle
//   i_data, i_last    : the byte and its end-of-image marker
//   o_word            : registered word buffer (stable while it is written)
//   o_word_ready      : this handshake completes a word (lane 3 or last)
//   o_last            : this handshake carries the end-of-image marker
//   o_overflow        : this handshake was discarded because the image is full
//   o_count           : bytes accepted into the image
// -----------------------------------------------------------------------------
module subservient_dbg_packer
    import subservient_dbg_pkg::*;
#(
    parameter int memsize = 8192,
    parameter int aw      = $clog2(memsize)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_ready,
    output logic        o_last,
    output logic        o_overflow,
    output logic [aw:0] o_count
);

    localparam logic [aw:0] MEMSIZE_C = (aw+1)'(memsize);
    localparam logic [aw:0] CNT_ONE_C = (aw+1)'(1);
    localparam logic [aw:0] CNT_ZERO_C = (aw+1)'(0);

    logic [31:0] word_q, word_d;
    logic [aw:0] count_q, count_d;
    logic [1:0]  lane_s;
    logic        full_s;

    // The byte goes to the lane selected by the running count.
    assign lane_s = count_q[1:0];
    assign full_s = (count_q == MEMSIZE_C);

    // Byte insertion, zero fill on the final byte, count and overflow.
    always_comb begin
        word_d       = word_q;
        count_d      = count_q;
        o_word_ready = 1'b0;
        o_last       = 1'b0;
        o_overflow   = 1'b0;
        if (i_clear) begin
            word_d  = 32'h0000_0000;
            count_d = CNT_ZERO_C;
        end else if (i_accept) begin
            o_last = i_last;
            if (full_s) begin
                // Byte is swallowed: no lane write, no count change.
                o_overflow = 1'b1;
            end else begin
                word_d = insert_byte(word_q, lane_s, i_data);
                if (i_last) begin
                    // Stale bytes from the previous word must not leak out.
                    word_d = word_d & lane_keep_mask(lane_s);
                end else begin
                    word_d = insert_byte(word_q, lane_s, i_data);
                end
                count_d      = count_q + CNT_ONE_C;
                o_word_ready = (lane_s == 2'd3) || i_last;
            end
        end else begin
            word_d  = word_q;
            count_d = count_q;
        end
    end

    // Word buffer and byte count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q  <= 32'h0000_0000;
            count_q <= CNT_ZERO_C;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign o_word  = word_q;
    assign o_count = count_q;

endmodule

// File: rtl/subservient_dbg_loader.sv
// -----------------------------------------------------------------------------
// subservient_dbg_loader
// Firmware loader in front of the subservient debug Wishbone port. Accepts a
// byte stream, writes it word by word to SRAM through the debug port while
// holding the SoC in debug mode, then releases debug mode after a drain delay.
// Parameters: memsize (bytes, power of two >= 16), aw, DRAIN_CYCLES (>= 2).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begins a load when idle
//   bus (master)   : byte stream in, Wishbone debug master out
//   o_debug_mode   : drives the SoC debug-mode input
//   o_done         : sticky, load finished and debug mode released
//   o_error        : sticky, overflow or readback mismatch
//   o_count        : bytes accepted into the image
// Build option: define SUBSERVIENT_DBG_LOADER_READBACK_EN to read every word
// back after writing it and flag mismatches.
// -----------------------------------------------------------------------------
module subservient_dbg_loader
    import subservient_dbg_pkg::*;
#(
    parameter int memsize      = 8192,
    parameter int aw           = $clog2(memsize),
    parameter int DRAIN_CYCLES = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    subservient_dbg_loader_if.master bus,
    output logic                     o_debug_mode,
    output logic                     o_done,
    output logic                     o_error,
    output logic [aw:0]              o_count
);

    // The counter is loaded one short because the first DRAIN cycle already
    // follows the cycle of the final ack (or final handshake).
    localparam logic [DRAIN_CW-1:0] DRAIN_LOAD_C = DRAIN_CW'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_ONE_C  = DRAIN_CW'(1);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         adr_q, adr_d;
    logic                dbg_q, dbg_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                last_word_q, last_word_d;
    logic [DRAIN_CW-1:0] drain_q, drain_d;

    logic                clear_s;
    logic                accept_s;
    logic [31:0]         word_s;
    logic                word_ready_s;
    logic                last_s;
    logic                ovf_s;
    logic [aw:0]         count_s;

    assign accept_s = bus.i_valid & ready_q;

    subservient_dbg_packer #(
        .memsize (memsize),
        .aw      (aw)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (clear_s),
        .i_accept     (accept_s),
        .i_data       (bus.i_data),
        .i_last       (bus.i_last),
        .o_word       (word_s),
        .o_word_ready (word_ready_s),
        .o_last       (last_s),
        .o_overflow   (ovf_s),
        .o_count      (count_s)
    );

`ifndef SUBSERVIENT_DBG_LOADER_READBACK_EN
    // Read data is not needed without readback checking.
    logic rdt_unused_s;
    assign rdt_unused_s = ^bus.i_wb_dbg_rdt;
`endif

    // Loader FSM: next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        stb_d       = 1'b0;
        we_d        = 1'b0;
        adr_d       = adr_q;
        dbg_d       = dbg_q;
        done_d      = done_q;
        err_d       = err_q;
        last_word_d = last_word_q;
        drain_d     = drain_q;
        clear_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    clear_s = 1'b1;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    dbg_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                ready_d = 1'b1;
                if (ovf_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (word_ready_s) begin
                    state_d     = ST_WRITE;
                    ready_d     = 1'b0;
                    stb_d       = 1'b1;
                    we_d        = 1'b1;
                    // The byte just taken sits at address count_s; clear its lane bits.
                    adr_d       = {{(32-aw){1'b0}}, count_s[aw-1:2], 2'b00};
                    last_word_d = last_s;
                end else if (ovf_s && last_s) begin
                    state_d = ST_DRAIN;
                    ready_d = 1'b0;
                    drain_d = DRAIN_LOAD_C;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                stb_d = 1'b1;
                we_d  = 1'b1;
                if (bus.i_wb_dbg_ack) begin
`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
                    we_d    = 1'b0;
                    state_d = ST_VERIFY;
`else
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (last_word_q) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD_C;
                    end else begin
                        state_d = ST_COLLECT;
                        ready_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = ST_WRITE;
                end
            end
`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
            ST_VERIFY: begin
                stb_d = 1'b1;
                we_d  = 1'b0;
                if (bus.i_wb_dbg_ack) begin
                    stb_d = 1'b0;
                    if (bus.i_wb_dbg_rdt != word_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (last_word_q) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD_C;
                    end else begin
                        state_d = ST_COLLECT;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_VERIFY;
                end
            end
`endif
            ST_DRAIN: begin
                if (drain_q <= DRAIN_ONE_C) begin
                    dbg_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (stb_d) begin
            sel_d = SEL_ALL;
        end else begin
            sel_d = 4'b0000;
        end
    end

    // State and registered-output flops; reset drops stb and debug mode at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0000;
            adr_q       <= 32'h0000_0000;
            dbg_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_word_q <= 1'b0;
            drain_q     <= {DRAIN_CW{1'b0}};
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dbg_q       <= dbg_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_word_q <= last_word_d;
            drain_q     <= drain_d;
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_wb_dbg_adr = adr_q;
    assign bus.o_wb_dbg_dat = word_s;
    assign bus.o_wb_dbg_sel = sel_q;
    assign bus.o_wb_dbg_we  = we_q;
    assign bus.o_wb_dbg_stb = stb_q;
    assign o_debug_mode     = dbg_q;
    assign o_done           = done_q;
    assign o_error          = err_q;
    assign o_count          = count_s;

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// -----------------------------------------------------------------------------
// tb_subservient_dbg_loader
// Two loader instances share stimulus: u_a (memsize 8192) and u_b (memsize 16).
// A table of images is streamed; expected Wishbone writes are queued as bytes
// are handshaken and compared when the bench's slave acks them.
// -----------------------------------------------------------------------------
module tb_subservient_dbg_loader;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  d_data;
    logic        d_valid, d_last;
    logic        ack;
    logic [31:0] rdt;
    int          cur;

    logic        dbg_a, done_a, err_a, dbg_b, done_b, err_b;
    logic [13:0] cnt_a;
    logic [4:0]  cnt_b;

    subservient_dbg_loader_if if_a();
    subservient_dbg_loader_if if_b();

    assign if_a.i_data       = d_data;
    assign if_a.i_valid      = d_valid;
    assign if_a.i_last       = d_last;
    assign if_a.i_wb_dbg_rdt = rdt;
    assign if_a.i_wb_dbg_ack = ack & (cur == 0);
    assign if_b.i_data       = d_data;
    assign if_b.i_valid      = d_valid;
    assign if_b.i_last       = d_last;
    assign if_b.i_wb_dbg_rdt = rdt;
    assign if_b.i_wb_dbg_ack = ack & (cur == 1);

    subservient_dbg_loader #(.memsize(8192)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .bus(if_a),
        .o_debug_mode(dbg_a), .o_done(done_a), .o_error(err_a), .o_count(cnt_a));

    subservient_dbg_loader #(.memsize(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .bus(if_b),
        .o_debug_mode(dbg_b), .o_done(done_b), .o_error(err_b), .o_count(cnt_b));

    // Outputs of the instance currently under test.
    logic        m_ready, m_stb, m_we, m_dbg, m_done, m_err;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    int          m_count;
    assign m_ready = cur == 1 ? if_b.o_ready      : if_a.o_ready;
    assign m_stb   = cur == 1 ? if_b.o_wb_dbg_stb : if_a.o_wb_dbg_stb;
    assign m_we    = cur == 1 ? if_b.o_wb_dbg_we  : if_a.o_wb_dbg_we;
    assign m_adr   = cur == 1 ? if_b.o_wb_dbg_adr : if_a.o_wb_dbg_adr;
    assign m_dat   = cur == 1 ? if_b.o_wb_dbg_dat : if_a.o_wb_dbg_dat;
    assign m_sel   = cur == 1 ? if_b.o_wb_dbg_sel : if_a.o_wb_dbg_sel;
    assign m_dbg   = cur == 1 ? dbg_b  : dbg_a;
    assign m_done  = cur == 1 ? done_b : done_a;
    assign m_err   = cur == 1 ? err_b  : err_a;
    assign m_count = cur == 1 ? int'(cnt_b) : int'(cnt_a);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int          n;
        logic [7:0]  base;
        logic [7:0]  step;
        int          dly;
        int          gap;
        int          dut;
        int          cnt;
        logic        err;
        logic [31:0] ladr;
        logic [31:0] ldat;
    } vec_t;

    // Slave and model state
    int          ack_dly = 0;
    int          bad_rd_idx = -1;
    int          rd_idx = 0;
    int          last_ack_cyc = 0;
    logic [31:0] last_adr, last_dat;
    int          mdl_cnt, mdl_msize, hs_cyc;
    logic [31:0] mdl_word;
    bit          last_disc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Wishbone slave: acks after ack_dly wait cycles, checks hold and scoreboard.
    initial begin
        int wait_cnt;
        int post;
        logic [31:0] h_adr, h_dat;
        logic h_we;
        wr_t e;
        ack = 1'b0; rdt = 32'h0; wait_cnt = 0; post = 0;
        h_adr = 32'h0; h_dat = 32'h0; h_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; wait_cnt = 0; post = 0;
            end else begin
                if (post == 1) begin
`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
                    chk("rb_follow_stb", m_stb, 1);
                    chk("rb_follow_we", m_we, 0);
                    chk("rb_follow_adr", m_adr, last_adr);
`else
                    chk("stb_drop_after_ack", m_stb, 0);
`endif
                end else if (post == 2) begin
                    chk("stb_drop_after_read", m_stb, 0);
                end
                post = 0;
                if (m_stb) begin
                    chk("ready_low_in_stb", m_ready, 0);
                    chk("sel_all", m_sel, 4'hF);
                    if (wait_cnt == 0) begin
                        h_adr = m_adr; h_dat = m_dat; h_we = m_we;
                    end else begin
                        chk("hold_adr", m_adr, h_adr);
                        chk("hold_dat", m_dat, h_dat);
                        chk("hold_we", m_we, h_we);
                    end
                    if (wait_cnt >= ack_dly) begin
                        ack = 1'b1;
                        wait_cnt = 0;
                        last_ack_cyc = cyc;
                        if (m_we) begin
                            if (exp_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, required none", m_adr, m_dat);
                            end else begin
                                e = exp_q.pop_front();
                                chk("wr_adr", m_adr, e.adr);
                                chk("wr_dat", m_dat, e.dat);
                            end
                            last_adr = m_adr; last_dat = m_dat;
                            post = 1;
                        end else begin
`ifndef SUBSERVIENT_DBG_LOADER_READBACK_EN
                            chk("we_with_stb", m_we, 1);
`endif
                            chk("rd_adr", m_adr, last_adr);
                            rdt = (rd_idx == bad_rd_idx) ? 32'hDEAD_BEEF : last_dat;
                            rd_idx++;
                            post = 2;
                        end
                    end else begin
                        ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    ack = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic model_accept(input logic [7:0] b, input logic lst);
        int lane;
        hs_cyc = cyc;
        if (mdl_cnt == mdl_msize) begin
            last_disc = lst;
        end else begin
            lane = mdl_cnt % 4;
            mdl_word[lane*8 +: 8] = b;
            mdl_cnt++;
            last_disc = 1'b0;
            if (lane == 3 || lst) begin
                exp_q.push_back('{adr: 32'((mdl_cnt - 1) / 4 * 4), dat: mdl_word});
                mdl_word = 32'h0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lst, input int gap);
        bit hs;
        hs = 1'b0;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            d_data = b;
            d_last = lst;
            d_valid = (gap != 0 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if (d_valid && m_ready) begin
                hs = 1'b1;
                model_accept(b, lst);
            end
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got no handshake for byte 0x%0h, required one", b);
        end
    endtask

    task automatic pulse_start(input int dut, input int msize);
        cur = dut;
        mdl_cnt = 0; mdl_msize = msize; mdl_word = 32'h0; last_disc = 1'b0; rd_idx = 0;
        @(negedge clk);
        if (dut == 1) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        chk("start_dbg", m_dbg, 1);
        chk("start_ready", m_ready, 1);
        chk("start_done_clr", m_done, 0);
        chk("start_err_clr", m_err, 0);
        chk("start_count_clr", m_count, 0);
    endtask

    task automatic wait_done();
        int dcyc;
        int ref_cyc;
        logic prev;
        dcyc = -1;
        prev = m_dbg;
        for (int t = 0; t < 400; t++) begin
            if (m_done) begin
                dcyc = cyc;
                break;
            end
            prev = m_dbg;
            @(negedge clk);
        end
        if (dcyc < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got o_done 0, required 1");
        end else begin
            ref_cyc = last_disc ? hs_cyc : last_ack_cyc;
            chk("drain_latency", 64'(dcyc - ref_cyc), 64'd10);
            chk("dbg_released", m_dbg, 0);
            chk("dbg_held_before_done", prev, 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        ack_dly = v.dly;
        pulse_start(v.dut, v.dut == 1 ? 16 : 8192);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.base + v.step * 8'(i), i == v.n - 1, v.gap);
        end
        @(negedge clk);
        d_valid = 1'b0; d_last = 1'b0;
        wait_done();
        chk("final_count", m_count, v.cnt);
        chk("final_error", m_err, v.err);
        chk("final_done", m_done, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("last_wr_adr", last_adr, v.ladr);
        chk("last_wr_dat", last_dat, v.ldat);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8,  8'h11, 8'h11, 0, 0, 0, 8,  1'b0, 32'h4, 32'h8877_6655};
        vecs[1] = '{5,  8'hA1, 8'h01, 0, 0, 0, 5,  1'b0, 32'h4, 32'h0000_00A5};
        vecs[2] = '{4,  8'h10, 8'h01, 3, 0, 0, 4,  1'b0, 32'h0, 32'h1312_1110};
        vecs[3] = '{1,  8'h5A, 8'h00, 1, 0, 0, 1,  1'b0, 32'h0, 32'h0000_005A};
        vecs[4] = '{11, 8'h30, 8'h03, 2, 1, 0, 11, 1'b0, 32'h8, 32'h004E_4B48};
        vecs[5] = '{20, 8'h01, 8'h01, 0, 0, 1, 16, 1'b1, 32'hC, 32'h100F_0E0D};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        d_data = 8'h00; d_valid = 1'b0; d_last = 1'b0; cur = 0;
        last_adr = 32'h0; last_dat = 32'h0;
        mdl_cnt = 0; mdl_msize = 8192; mdl_word = 32'h0; hs_cyc = 0; last_disc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stb", if_a.o_wb_dbg_stb, 0);
        chk("rst_ready", if_a.o_ready, 0);
        chk("rst_dbg", dbg_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_adr", if_a.o_wb_dbg_adr, 0);
        chk("rst_b_dbg", dbg_b, 0);
        #2 rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

`ifdef SUBSERVIENT_DBG_LOADER_READBACK_EN
        // Second read returns a corrupted word; loading must still finish.
        bad_rd_idx = 1;
        run_vec('{8, 8'h11, 8'h11, 0, 0, 0, 8, 1'b1, 32'h4, 32'h8877_6655});
        bad_rd_idx = -1;
`endif

        // Reset while a write is outstanding, then a clean reload.
        ack_dly = 60;
        pulse_start(0, 8192);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h01 + 8'(i), 1'b0, 0);
        end
        @(negedge clk);
        d_valid = 1'b0;
        for (int t = 0; t < 10 && !m_stb; t++) @(negedge clk);
        chk("pre_reset_stb", m_stb, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stb", if_a.o_wb_dbg_stb, 0);
        chk("arst_dbg", dbg_a, 0);
        chk("arst_we", if_a.o_wb_dbg_we, 0);
        chk("arst_sel", if_a.o_wb_dbg_sel, 0);
        chk("arst_adr_dat", {if_a.o_wb_dbg_adr, if_a.o_wb_dbg_dat}, 64'h0);
        chk("arst_ready", if_a.o_ready, 0);
        chk("arst_count", cnt_a, 0);
        chk("arst_done_err", {done_a, err_a}, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subservient_dbg_loader.md
# subservient_dbg_loader

Firmware loader sitting directly upstream of the subservient debug Wishbone port. It accepts a byte stream with valid/ready handshake, packs bytes little-endian into 32-bit words, and issues one full-word Wishbone write per word, zero-padding the final partial word. It owns `o_debug_mode`: it holds the SoC in debug mode while loading, and releases it after a fixed drain period.

## Interface
Parameters:
- `memsize`, 8192, SRAM size in bytes; power of two, at least 16.
- `aw`, `$clog2(memsize)`, byte address width.
- `DRAIN_CYCLES`, 10, cycles debug mode stays asserted after the last write.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: single-cycle pulse that begins a load; ignored unless in IDLE.
- `i_data` in 8: stream byte.
- `i_valid` in 1: byte valid.
- `i_last` in 1: qualifies the final byte of the image.
- `o_ready` out 1: byte accepted when `i_valid & o_ready`.
- `o_debug_mode` out 1: to SoC `i_debug_mode`.
- `o_wb_dbg_adr` out 32, `o_wb_dbg_dat` out 32, `o_wb_dbg_sel` out 4, `o_wb_dbg_we` out 1, `o_wb_dbg_stb` out 1: Wishbone master.
- `i_wb_dbg_rdt` in 32, `i_wb_dbg_ack` in 1: Wishbone response.
- `o_done` out 1: sticky; load complete and debug mode released.
- `o_error` out 1: sticky; overflow or readback mismatch.
- `o_count` out aw+1: bytes accepted into the image.

## Operation
- Reset values: all outputs 0, state IDLE.
- IDLE: `o_ready`=0. On `i_start`, clear count, error, and done; set `o_debug_mode`=1; go to COLLECT.
- COLLECT: `o_ready`=1. On handshake, write the byte to lane `o_count[1:0]` of the word buffer and increment `o_count`.
  - If the accepted byte completes lane 3, or `i_last`=1, go to WRITE.
  - On `i_last`, lanes above the last written lane are forced to 0.
- WRITE: `stb`=1, `we`=1, `sel`=4'b1111.
  - `adr` = word index × 4, where word index = (count−1)>>2.
  - `dat` = word buffer.
  - Outputs are held stable until `ack`.
  - On `ack`: go to VERIFY if the macro is enabled; otherwise go to DRAIN if the word was the last, else to COLLECT.
- DRAIN: `o_ready`=0. Count `DRAIN_CYCLES` cycles, then set `o_debug_mode`=0 and `o_done`=1, and go to IDLE.
- Overflow: a byte handshaken when `o_count`==memsize is consumed but discarded. It sets `o_error` and does not increment the count. `i_last` on a discarded byte still goes directly to DRAIN.
- An empty image is not supported; the stream always carries at least one byte.
- Reset asserted mid-operation: `stb` and `debug_mode` drop asynchronously, and the partial word is lost.

## Timing
- COLLECT accepts one byte per cycle.
- `stb` rises in the cycle after the handshake that completes a word.
- `ack` may arrive in the first `stb` cycle. `stb` falls in the cycle after `ack`. `o_ready` returns in that same cycle (no VERIFY).
- Minimum time per word without readback: 4 collect cycles + 1 strobe cycle.
- `o_done` and debug-mode release occur exactly `DRAIN_CYCLES` cycles after the final `ack` (or after the final handshake on overflow).
- `i_valid` during WRITE, VERIFY, DRAIN or IDLE is not accepted.

## Configuration
- `SUBSERVIENT_DBG_LOADER_READBACK_EN` defined: VERIFY state is compiled in.
  - Same `adr`, `we`=0, `sel`=4'b1111, `stb`=1.
  - On `ack`, compare `i_wb_dbg_rdt` with the written word; a mismatch sets `o_error`.
  - Then proceed as after WRITE.
- Not defined: no VERIFY state, `i_wb_dbg_rdt` is unused, and `we` is constantly 1 whenever `stb` is high.

## Structure
- Shared package `subservient_dbg_pkg` holds:
  - The state enum (IDLE, COLLECT, WRITE, VERIFY, DRAIN).
  - The `SEL_ALL`=4'b1111 constant.
  - The drain counter width.
- Natural sub-module `subservient_dbg_packer`: byte-lane assembly, zero fill, and the count/overflow logic, exposing `word`, `word_ready`, and `last`. The top level holds the FSM and the Wishbone logic.

## Test plan
- Bytes 0x11..0x88, with `i_last` on 0x88 and ack on the first strobe cycle:
  - Writes adr 0x0 dat 0x44332211, then adr 0x4 dat 0x88776655.
  - `o_count`=8.
  - `o_done` rises 10 cycles after the second ack, with `o_debug_mode` falling in the same cycle.
- Five bytes 0xA1..0xA5 with `i_last` on the fifth:
  - Second write is adr 0x4 dat 0x000000A5.
  - `o_error`=0.
- Ack delayed 3 cycles:
  - `stb`, `adr` and `dat` remain stable for 4 cycles and `o_ready`=0 throughout.
  - `stb` is low in the cycle after ack.
- `memsize`=16, 20 bytes streamed:
  - Exactly 4 writes (adr 0x0..0xC).
  - `o_count`=16, `o_error`=1, `o_done`=1.
- READBACK enabled, slave returns 0xDEADBEEF on the second read:
  - Read cycles follow each write at the same adr.
  - `o_error`=1 after the second verify; loading continues to `o_done`.
- `i_rst_n` pulsed low while `stb`=1:
  - All outputs are 0 immediately.
  - A fresh `i_start` then loads correctly from adr 0x0.
